// File: rtl/cosim_step_sequencer.sv
// cosim_step_sequencer
//   Lock-steps one retiring hart against the reference model. Retirement
//   records are queued in a small FIFO. For each record the block requests one
//   model step, compares the model PC, then scans the model's register-write
//   commit log against the record's integer-register write. It reports one
//   result per instruction and halts on the first divergence.
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   retire_*               DUT retirement record (valid/ready handshake)
//   step_req_o/step_ack_i  model step handshake
//   model_pc_i             PC the model just stepped
//   model_reg_*            commit-log read port (idx out, entry fields in)
//   result_*               per-instruction result pulse, code and DUT PC
//   halted_o               sticky divergence flag
//   checked_count_o        number of matching instructions
module cosim_step_sequencer #(
  parameter int unsigned FifoDepth        = 4,
  parameter int unsigned CommitLogEntries = 16,
  parameter int unsigned XregW            = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                retire_valid_i,
  output logic                                retire_ready_o,
  input  logic [XregW-1:0]                    retire_pc_i,
  input  logic                                retire_rd_we_i,
  input  logic [4:0]                          retire_rd_i,
  input  logic [XregW-1:0]                    retire_rd_wdata_i,
  output logic                                step_req_o,
  input  logic                                step_ack_i,
  input  logic [XregW-1:0]                    model_pc_i,
  input  logic [4:0]                          model_reg_cnt_i,
  output logic [$clog2(CommitLogEntries)-1:0] model_reg_idx_o,
  input  logic [3:0]                          model_reg_type_i,
  input  logic [11:0]                         model_reg_id_i,
  input  logic [XregW-1:0]                    model_reg_value_i,
  output logic                                result_valid_o,
  output logic [1:0]                          result_code_o,
  output logic [XregW-1:0]                    result_pc_o,
  output logic                                halted_o,
  output logic [31:0]                         checked_count_o
);

  localparam int unsigned AddrW = $clog2(FifoDepth);
  localparam int unsigned IdxW  = $clog2(CommitLogEntries);
  localparam int unsigned CntW  = $clog2(CommitLogEntries + 1);

  typedef enum logic [2:0] {IDLE, STEP, CHECK_PC, SCAN, REPORT, HALT} state_e;

  typedef struct packed {
    logic [XregW-1:0] pc;
    logic             rd_we;
    logic [4:0]       rd;
    logic [XregW-1:0] wdata;
  } rec_t;

  state_e           state_q, state_d;
  rec_t             mem_q [FifoDepth];
  rec_t             head;
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full, empty, push, pop;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_clamp;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             found_q, found_d, extra_q, extra_d;
  logic [XregW-1:0] value_q, value_d;
  logic [1:0]       code_q, code_d;
  logic             halted_q, halted_d;
  logic [31:0]      checked_q, checked_d;
  logic             eff_we, is_xreg, hit, extra_ent;

  // FIFO bookkeeping: pointers carry one wrap bit to tell full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign head  = mem_q[rd_ptr_q[AddrW-1:0]];

  assign retire_ready_o = !full && !halted_q;
  assign push           = retire_valid_i && retire_ready_o;

  assign wr_ptr_d = push ? wr_ptr_q + (AddrW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + (AddrW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= '{pc: retire_pc_i, rd_we: retire_rd_we_i,
                                      rd: retire_rd_i, wdata: retire_rd_wdata_i};
    end
  end

  // x0 writes are architecturally invisible, on both sides of the compare.
  assign eff_we    = head.rd_we && (head.rd != 5'd0);
  assign is_xreg   = (model_reg_type_i == 4'd0) && (model_reg_id_i != 12'd0);
  assign hit       = is_xreg && (model_reg_id_i == {7'd0, head.rd});
  assign extra_ent = is_xreg && (!head.rd_we || (model_reg_id_i != {7'd0, head.rd}));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    found_d        = found_q;
    extra_d        = extra_q;
    value_d        = value_q;
    code_d         = code_q;
    halted_d       = halted_q;
    checked_d      = checked_q;
    pop            = 1'b0;
    step_req_o     = 1'b0;
    result_valid_o = 1'b0;
    cnt_clamp      = (32'(model_reg_cnt_i) > CommitLogEntries) ?
                     CntW'(CommitLogEntries) : CntW'(model_reg_cnt_i);

    case (state_q)
      IDLE: begin
        if (!empty) state_d = STEP;
      end
      STEP: begin
        step_req_o = 1'b1;
        if (step_ack_i) state_d = CHECK_PC;
      end
      CHECK_PC: begin
        cnt_d   = cnt_clamp;
        idx_d   = '0;
        found_d = 1'b0;
        extra_d = 1'b0;
        value_d = '0;
        if (model_pc_i != head.pc) begin
          code_d  = 2'b01;
          state_d = REPORT;
        end else if (cnt_clamp == '0) begin
          code_d  = eff_we ? 2'b10 : 2'b00;
          state_d = REPORT;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          found_d = 1'b1;
          value_d = model_reg_value_i;
        end
        if (extra_ent) extra_d = 1'b1;
        // The final entry's hit/extra must feed the verdict, so the code is
        // formed from the _d values in the same cycle.
        if (CntW'(idx_q) + CntW'(1) == cnt_q) begin
          idx_d   = '0;
          state_d = REPORT;
          if (extra_d || (found_d != eff_we))             code_d = 2'b10;
          else if (found_d && (value_d != head.wdata))    code_d = 2'b11;
          else                                            code_d = 2'b00;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      REPORT: begin
        result_valid_o = 1'b1;
        pop            = 1'b1;
        if (code_q == 2'b00) begin
          checked_d = checked_q + 32'd1;
          state_d   = IDLE;
        end else begin
          halted_d = 1'b1;
          state_d  = HALT;
        end
      end
      HALT: begin
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      found_q   <= 1'b0;
      extra_q   <= 1'b0;
      value_q   <= '0;
      code_q    <= 2'b00;
      halted_q  <= 1'b0;
      checked_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      found_q   <= found_d;
      extra_q   <= extra_d;
      value_q   <= value_d;
      code_q    <= code_d;
      halted_q  <= halted_d;
      checked_q <= checked_d;
    end
  end

  assign model_reg_idx_o = idx_q;
  assign result_code_o   = code_q;
  assign result_pc_o     = result_valid_o ? head.pc : '0;
  assign halted_o        = halted_q;
  assign checked_count_o = checked_q;

endmodule

// File: tb/tb_cosim_step_sequencer.sv
// Directed bench for cosim_step_sequencer: a model responder acks step
// requests after a programmable delay and serves per-step PC / commit-log
// tables; a monitor records every result pulse.
module tb_cosim_step_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        retire_valid_i = 1'b0;
  logic        retire_ready_o;
  logic [63:0] retire_pc_i = '0;
  logic        retire_rd_we_i = 1'b0;
  logic [4:0]  retire_rd_i = '0;
  logic [63:0] retire_rd_wdata_i = '0;
  logic        step_req_o;
  logic        step_ack_i = 1'b0;
  logic [63:0] model_pc_i;
  logic [4:0]  model_reg_cnt_i;
  logic [3:0]  model_reg_idx_o;
  logic [3:0]  model_reg_type_i;
  logic [11:0] model_reg_id_i;
  logic [63:0] model_reg_value_i;
  logic        result_valid_o;
  logic [1:0]  result_code_o;
  logic [63:0] result_pc_o;
  logic        halted_o;
  logic [31:0] checked_count_o;

  always #5 clk_i = ~clk_i;

  cosim_step_sequencer #(.FifoDepth(4), .CommitLogEntries(16), .XregW(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .retire_valid_i(retire_valid_i), .retire_ready_o(retire_ready_o),
    .retire_pc_i(retire_pc_i), .retire_rd_we_i(retire_rd_we_i),
    .retire_rd_i(retire_rd_i), .retire_rd_wdata_i(retire_rd_wdata_i),
    .step_req_o(step_req_o), .step_ack_i(step_ack_i),
    .model_pc_i(model_pc_i), .model_reg_cnt_i(model_reg_cnt_i),
    .model_reg_idx_o(model_reg_idx_o), .model_reg_type_i(model_reg_type_i),
    .model_reg_id_i(model_reg_id_i), .model_reg_value_i(model_reg_value_i),
    .result_valid_o(result_valid_o), .result_code_o(result_code_o),
    .result_pc_o(result_pc_o), .halted_o(halted_o),
    .checked_count_o(checked_count_o)
  );

  // Per-step model tables, selected by the step index the responder latched.
  logic [63:0] mp_pc  [8];
  logic [4:0]  mp_cnt [8];
  logic [3:0]  lt [8][16];
  logic [11:0] li [8][16];
  logic [63:0] lv [8][16];
  logic [2:0]  cur_step;
  int          k, req_cyc, ack_dly;

  assign model_pc_i        = mp_pc[cur_step];
  assign model_reg_cnt_i   = mp_cnt[cur_step];
  assign model_reg_type_i  = lt[cur_step][model_reg_idx_o];
  assign model_reg_id_i    = li[cur_step][model_reg_idx_o];
  assign model_reg_value_i = lv[cur_step][model_reg_idx_o];

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      k <= 0; req_cyc <= 0; step_ack_i <= 1'b0; cur_step <= '0;
    end else if (step_req_o) begin
      if (req_cyc >= ack_dly) begin
        step_ack_i <= 1'b1;
        cur_step   <= k[2:0];
        k          <= k + 1;
      end
      req_cyc <= req_cyc + 1;
    end else begin
      step_ack_i <= 1'b0;
      req_cyc    <= 0;
    end
  end

  logic [63:0] res_pc   [16];
  logic [1:0]  res_code [16];
  int          res_n;

  always @(negedge clk_i) begin
    if (!rst_ni) res_n <= 0;
    else if (result_valid_o && res_n < 16) begin
      res_pc[res_n]   <= result_pc_o;
      res_code[res_n] <= result_code_o;
      res_n           <= res_n + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    retire_valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic push_rec(input logic [63:0] pc, input logic we,
                          input logic [4:0] rd, input logic [63:0] wd);
    bit pushed = 1'b0;
    retire_valid_i = 1'b1; retire_pc_i = pc; retire_rd_we_i = we;
    retire_rd_i = rd; retire_rd_wdata_i = wd;
    for (int i = 0; i < 100; i++) begin
      if (retire_ready_o) begin
        @(negedge clk_i);
        pushed = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    retire_valid_i = 1'b0;
    if (!pushed) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_result(input int max, output int lat);
    lat = 0;
    while (!result_valid_o && lat < max) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic set_ent(input int s, input int e, input logic [3:0] t,
                         input logic [11:0] id, input logic [63:0] v);
    lt[s][e] = t; li[s][e] = id; lv[s][e] = v;
  endtask

  task automatic check_no_step(input string tag);
    int hits = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (step_req_o) hits++;
    end
    chk(tag, 64'(hits), 64'd0);
  endtask

  int lat;

  initial begin
    ack_dly = 0;
    for (int s = 0; s < 8; s++) begin
      mp_pc[s] = '0; mp_cnt[s] = '0;
      for (int e = 0; e < 16; e++) set_ent(s, e, 4'd4, 12'h300, 64'h0);
    end

    // Reset state
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_ready",   64'(retire_ready_o), 64'd1);
    chk("rst_stepreq", 64'(step_req_o), 64'd0);
    chk("rst_idx",     64'(model_reg_idx_o), 64'd0);
    chk("rst_valid",   64'(result_valid_o), 64'd0);
    chk("rst_code",    64'(result_code_o), 64'd0);
    chk("rst_pc",      result_pc_o, 64'd0);
    chk("rst_halted",  64'(halted_o), 64'd0);
    chk("rst_count",   64'(checked_count_o), 64'd0);

    // Single matching retire (step 0), rd=0 with empty log (step 1),
    // clamped log of 20 with the hit in the 16th entry (step 2)
    do_reset();
    mp_pc[0] = 64'h8000_0000; mp_cnt[0] = 5'd1;
    set_ent(0, 0, 4'd0, 12'd5, 64'h1234);
    mp_pc[1] = 64'h8000_0010; mp_cnt[1] = 5'd0;
    mp_pc[2] = 64'h8000_0020; mp_cnt[2] = 5'd20;
    for (int e = 0; e < 15; e++) set_ent(2, e, 4'd4, 12'h340, 64'h0);
    set_ent(2, 15, 4'd0, 12'd9, 64'h99);

    push_rec(64'h8000_0000, 1'b1, 5'd5, 64'h1234);
    wait_result(50, lat);
    chk("single_lat",  64'(lat), 64'd4);
    chk("single_code", 64'(result_code_o), 64'd0);
    chk("single_pc",   result_pc_o, 64'h8000_0000);
    @(negedge clk_i);
    chk("single_count", 64'(checked_count_o), 64'd1);
    chk("single_pulse", 64'(result_valid_o), 64'd0);

    push_rec(64'h8000_0010, 1'b1, 5'd0, 64'h55);
    wait_result(50, lat);
    chk("x0_lat",  64'(lat), 64'd3);
    chk("x0_code", 64'(result_code_o), 64'd0);
    @(negedge clk_i);

    push_rec(64'h8000_0020, 1'b1, 5'd9, 64'h99);
    wait_result(80, lat);
    chk("clamp_lat",  64'(lat), 64'd19);
    chk("clamp_code", 64'(result_code_o), 64'd0);
    @(negedge clk_i);
    chk("clamp_count", 64'(checked_count_o), 64'd3);
    chk("clamp_halted", 64'(halted_o), 64'd0);

    // Backpressure: 5 back-to-back records, ack 3 cycles late
    do_reset();
    ack_dly = 3;
    for (int i = 0; i < 5; i++) begin
      mp_pc[i] = 64'h1000 + 64'(4 * i); mp_cnt[i] = 5'd1;
      set_ent(i, 0, 4'd0, 12'(i + 1), 64'h100 + 64'(i));
    end
    for (int i = 0; i < 5; i++) begin
      push_rec(64'h1000 + 64'(4 * i), 1'b1, 5'(i + 1), 64'h100 + 64'(i));
      if (i == 3) chk("bp_ready_full", 64'(retire_ready_o), 64'd0);
    end
    for (int i = 0; i < 300 && res_n < 5; i++) @(negedge clk_i);
    chk("bp_results", 64'(res_n), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_pc%0d", i), res_pc[i], 64'h1000 + 64'(4 * i));
      chk($sformatf("bp_code%0d", i), 64'(res_code[i]), 64'd0);
    end
    chk("bp_count", 64'(checked_count_o), 64'd5);
    ack_dly = 0;

    // Value mismatch among CSR/FREG noise
    do_reset();
    mp_pc[0] = 64'h2000; mp_cnt[0] = 5'd3;
    set_ent(0, 0, 4'd4, 12'h300, 64'h55);
    set_ent(0, 1, 4'd0, 12'd7,   64'hAA);
    set_ent(0, 2, 4'd1, 12'd1,   64'h77);
    push_rec(64'h2000, 1'b1, 5'd7, 64'hAB);
    wait_result(50, lat);
    chk("val_lat",  64'(lat), 64'd6);
    chk("val_code", 64'(result_code_o), 64'd3);
    @(negedge clk_i);
    chk("val_halted", 64'(halted_o), 64'd1);
    chk("val_ready",  64'(retire_ready_o), 64'd0);
    chk("val_count",  64'(checked_count_o), 64'd0);

    // PC divergence
    do_reset();
    mp_pc[0] = 64'h8000_0004; mp_cnt[0] = 5'd1;
    set_ent(0, 0, 4'd0, 12'd1, 64'h1);
    push_rec(64'h8000_0000, 1'b1, 5'd1, 64'h1);
    wait_result(50, lat);
    chk("pc_lat",  64'(lat), 64'd3);
    chk("pc_code", 64'(result_code_o), 64'd1);
    chk("pc_pc",   result_pc_o, 64'h8000_0000);
    @(negedge clk_i);
    chk("pc_halted", 64'(halted_o), 64'd1);
    chk("pc_ready",  64'(retire_ready_o), 64'd0);
    check_no_step("pc_no_step");

    // Write-set mismatch: DUT writes nothing, model logs x3
    do_reset();
    mp_pc[0] = 64'h3000; mp_cnt[0] = 5'd1;
    set_ent(0, 0, 4'd0, 12'd3, 64'h3);
    push_rec(64'h3000, 1'b0, 5'd3, 64'h0);
    wait_result(50, lat);
    chk("ws_lat",  64'(lat), 64'd4);
    chk("ws_code", 64'(result_code_o), 64'd2);
    @(negedge clk_i);
    chk("ws_halted", 64'(halted_o), 64'd1);

    // Asynchronous reset while a step is outstanding with 2 records queued
    do_reset();
    ack_dly = 1000;
    mp_pc[0] = 64'h4000; mp_cnt[0] = 5'd0;
    for (int i = 0; i < 3; i++) push_rec(64'h4000 + 64'(4 * i), 1'b0, 5'd0, 64'h0);
    for (int i = 0; i < 20 && !step_req_o; i++) @(negedge clk_i);
    chk("ar_stepreq_before", 64'(step_req_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_stepreq", 64'(step_req_o), 64'd0);
    chk("ar_valid",   64'(result_valid_o), 64'd0);
    chk("ar_halted",  64'(halted_o), 64'd0);
    chk("ar_idx",     64'(model_reg_idx_o), 64'd0);
    chk("ar_code",    64'(result_code_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ar_ready", 64'(retire_ready_o), 64'd1);
    check_no_step("ar_fifo_empty");
    chk("ar_count", 64'(checked_count_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cosim_step_sequencer.md
# cosim_step_sequencer

Sequences the lock-step co-simulation of one retiring hart against the Spike reference model. Buffers DUT retirement records in a small FIFO and issues one model step request per record. After each step it compares the model PC and the model's register-write commit log against the record. Results are reported per instruction, and the block halts on the first divergence. It sits between the DUT retire port and the DPI-facing model adapter that wraps the step and commit-log accessors.

## Interface
- FifoDepth, 4: retirement FIFO entries (power of two, ≥2)
- CommitLogEntries, 16: max reg-write log entries per model step
- XregW, 64: register/PC width
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- retire_valid_i  in  1  DUT retirement record valid
- retire_ready_o  out  1  FIFO can accept a record
- retire_pc_i  in  XregW  retired PC
- retire_rd_we_i  in  1  instruction wrote an integer register
- retire_rd_i  in  5  destination xreg id
- retire_rd_wdata_i  in  XregW  written value
- step_req_o  out  1  request one model step
- step_ack_i  in  1  step done; model_* inputs valid until next step_req_o
- model_pc_i  in  XregW  PC of the instruction the model just stepped
- model_reg_cnt_i  in  5  valid reg-write log entries
- model_reg_idx_o  out  $clog2(CommitLogEntries)  log entry being read
- model_reg_type_i  in  4  key type of entry idx (0=XREG, 1=FREG, 4=CSR, ...)
- model_reg_id_i  in  12  register id of entry idx
- model_reg_value_i  in  XregW  low XregW bits of entry value
- result_valid_o  out  1  one-cycle per-instruction result pulse
- result_code_o  out  2  00 match, 01 PC mismatch, 10 write-set mismatch, 11 value mismatch
- result_pc_o  out  XregW  DUT PC of the reported instruction
- halted_o  out  1  sticky: a mismatch occurred
- checked_count_o  out  32  instructions reported as matching

## Operation
- FIFO: push on retire_valid_i && retire_ready_o. retire_ready_o = !full && !halted_o. Pop occurs only in REPORT. A push into an empty FIFO is visible to the FSM next cycle.
- FSM states: IDLE, STEP, CHECK_PC, SCAN, REPORT, HALT.
- IDLE → STEP when FIFO is non-empty.
- STEP: step_req_o=1 (Moore). It holds until step_ack_i is sampled 1, then goes to CHECK_PC.
- CHECK_PC: latch cnt = min(model_reg_cnt_i, CommitLogEntries).
  - If model_pc_i ≠ head pc: code 01 → REPORT.
  - Else if cnt=0 → REPORT.
  - Else → SCAN with idx=0.
- SCAN: model_reg_idx_o=idx; model_reg_* is a combinational same-cycle read. Each cycle, the entry with type XREG and id≠0 and id=head rd is a hit.
  - Hit sets found and latches its value. A later hit overwrites it, so the last write wins.
  - An XREG entry with id≠0 and id≠rd (or any such entry when rd_we=0) sets extra.
  - FREG/CSR/VREG entries are ignored.
  - idx increments; after idx=cnt-1 → REPORT.
- Effective DUT write: rd_we && rd≠0.
- Code evaluation (priority 01 > 10 > 11 > 00):
  - 10 if extra, or found ≠ effective write.
  - 11 if found and the latched value ≠ rd_wdata.
- REPORT: result_valid_o=1; result_pc_o = head pc; pop FIFO.
  - Code 00: checked_count_o += 1 (wraps modulo 2^32) → IDLE.
  - Otherwise: halted_o←1 → HALT.
- HALT: absorbing until reset. No step requests or pops; FIFO contents are frozen.

## Timing
- Reset values: retire_ready_o=1 once rst_ni deasserts (0 while asserted is acceptable), step_req_o=0, model_reg_idx_o=0, result_valid_o=0, result_code_o=00, result_pc_o=0, halted_o=0, checked_count_o=0. FIFO is empty and FSM is in IDLE.
- Per-instruction latency with step_ack_i returned in the first STEP cycle: cycles = 4 + cnt (IDLE, STEP, CHECK_PC, SCAN×cnt, REPORT). Each extra ack wait cycle adds 1.
- Push while full is blocked by ready. A simultaneous push and pop in REPORT is allowed, and occupancy is unchanged.
- step_ack_i outside STEP is ignored.
- Async reset mid-operation clears everything immediately; step_req_o drops without waiting for ack.
- model_reg_cnt_i > CommitLogEntries is clamped; entries beyond the clamp are never read.

## Test plan
- Single retire: pc=0x8000_0000, rd=5, wdata=0x1234. Model returns the same pc and one XREG id5 entry with 0x1234, ack same cycle → result 00 five cycles after dequeue start; checked_count_o=1.
- PC divergence: model_pc_i=0x8000_0004 vs 0x8000_0000 → code 01, halted_o=1, retire_ready_o=0, and no further step_req_o.
- Write-set mismatch: DUT rd_we=0, model log has XREG id3. Separately, DUT rd=0 with log empty → first gives 10; second gives 00.
- Value mismatch with noise: log of 3 entries (CSR 0x300, XREG id7=0xAA, FREG id1), DUT rd=7 wdata=0xAB → code 11 after 3 SCAN cycles.
- Backpressure: push 5 records back-to-back with FifoDepth=4 and ack delayed 3 cycles → ready drops after the 4th push; all 5 are reported in order; checked_count_o=5.
- Reset while step_req_o=1 with 2 queued entries → all outputs return to reset values asynchronously; the FIFO is empty afterwards.
